// File: rtl/ttt_pkg.sv
// Shared constants and state encoding for the tic-tac-toe keystroke parser.
package ttt_pkg;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_R_LO = 8'h72;
    localparam logic [7:0] CH_R_UP = 8'h52;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [1:0] ERR_OCCUPIED = 2'b01;
    localparam logic [1:0] ERR_UNKNOWN  = 2'b10;
    localparam logic [1:0] ERR_OVER     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/win_detect.sv
// Combinational win/draw detector over row-major boards (bit i = cell i+1).
module win_detect
    import ttt_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic [ROWS*COLS-1:0] board_a,
    input  logic [ROWS*COLS-1:0] board_b,
    output logic [1:0]           winner
);

    logic [ROWS-1:0] w_row_a, w_row_b;
    logic [COLS-1:0] w_col_a, w_col_b;
    logic [1:0]      w_diag_a, w_diag_b;
    logic            w_win_a, w_win_b, w_full;

    genvar r, c, k;

    for (r = 0; r < ROWS; r++) begin : g_row
        assign w_row_a[r] = &board_a[r*COLS +: COLS];
        assign w_row_b[r] = &board_b[r*COLS +: COLS];
    end

    for (c = 0; c < COLS; c++) begin : g_col
        logic [ROWS-1:0] w_ca, w_cb;
        for (k = 0; k < ROWS; k++) begin : g_cell
            assign w_ca[k] = board_a[k*COLS + c];
            assign w_cb[k] = board_b[k*COLS + c];
        end
        assign w_col_a[c] = &w_ca;
        assign w_col_b[c] = &w_cb;
    end

    if (ROWS == COLS) begin : g_diag
        logic [ROWS-1:0] w_d0a, w_d0b, w_d1a, w_d1b;
        for (r = 0; r < ROWS; r++) begin : g_dcell
            assign w_d0a[r] = board_a[r*COLS + r];
            assign w_d0b[r] = board_b[r*COLS + r];
            assign w_d1a[r] = board_a[r*COLS + COLS - 1 - r];
            assign w_d1b[r] = board_b[r*COLS + COLS - 1 - r];
        end
        assign w_diag_a = {&w_d1a, &w_d0a};
        assign w_diag_b = {&w_d1b, &w_d0b};
    end else begin : g_nodiag
        assign w_diag_a = '0;
        assign w_diag_b = '0;
    end

    assign w_win_a = (|w_row_a) | (|w_col_a) | (|w_diag_a);
    assign w_win_b = (|w_row_b) | (|w_col_b) | (|w_diag_b);
    assign w_full  = &(board_a | board_b);

    always_comb begin
        winner = WIN_NONE;
        if (w_win_a)      winner = WIN_A;
        else if (w_win_b) winner = WIN_B;
        else if (w_full)  winner = WIN_DRAW;
    end

endmodule

// File: rtl/move_parser.sv
// Decodes player keystrokes into board updates and hands each change to print_board.
module move_parser
    import ttt_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_rd,
    input  logic [7:0]           rx_dout,
    input  logic                 print_ready,
    output logic                 print_wr,
    output logic [ROWS*COLS-1:0] board_a,
    output logic [ROWS*COLS-1:0] board_b,
    output logic                 turn,
    output logic [1:0]           winner,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic                 overflow
);

    localparam int N = ROWS * COLS;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_board_a, r_board_b, w_board_a_nxt, w_board_b_nxt;
    logic           r_turn, w_turn_nxt;
    logic           r_pend_valid, w_pend_valid_nxt;
    logic [7:0]     r_pend_byte, w_pend_byte_nxt;
    logic [1:0]     r_ack_cnt, w_ack_cnt_nxt;
    logic           r_err, w_err_nxt;
    logic [1:0]     r_err_code, w_err_code_nxt;
    logic           r_ovf, w_ovf_nxt;

    logic           w_decode;
    logic [7:0]     w_byte;
    logic           w_is_digit;
    logic [3:0]     w_cell;
    logic [N-1:0]   w_mask;
    logic [1:0]     w_winner;

    win_detect #(.ROWS(ROWS), .COLS(COLS)) u_win (
        .board_a (r_board_a),
        .board_b (r_board_b),
        .winner  (w_winner)
    );

    // Pending byte has priority so bytes are decoded in arrival order.
    assign w_decode   = (r_state == IDLE) && (r_pend_valid || rx_rd);
    assign w_byte     = r_pend_valid ? r_pend_byte : rx_dout;
    assign w_is_digit = (w_byte > CH_0) && (w_byte <= CH_0 + 8'(N));
    assign w_cell     = w_byte[3:0] - 4'd1;
    assign w_mask     = {{(N-1){1'b0}}, 1'b1} << w_cell;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_board_a    <= '0;
            r_board_b    <= '0;
            r_turn       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_byte  <= '0;
            r_ack_cnt    <= '0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_board_a    <= w_board_a_nxt;
            r_board_b    <= w_board_b_nxt;
            r_turn       <= w_turn_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_byte  <= w_pend_byte_nxt;
            r_ack_cnt    <= w_ack_cnt_nxt;
            r_err        <= w_err_nxt;
            r_err_code   <= w_err_code_nxt;
            r_ovf        <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_board_a_nxt    = r_board_a;
        w_board_b_nxt    = r_board_b;
        w_turn_nxt       = r_turn;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_byte_nxt  = r_pend_byte;
        w_ack_cnt_nxt    = r_ack_cnt;
        w_err_nxt        = 1'b0;
        w_err_code_nxt   = r_err_code;
        w_ovf_nxt        = 1'b0;
        print_wr         = 1'b0;

        if (rx_rd && !(r_state == IDLE && !r_pend_valid)) begin
            if (r_pend_valid && r_state != IDLE) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_pend_valid_nxt = 1'b1;
                w_pend_byte_nxt  = rx_dout;
            end
        end else if (r_state == IDLE && r_pend_valid) begin
            w_pend_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_decode) begin
                    if (w_is_digit) begin
                        if (w_winner != WIN_NONE) begin
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_OVER;
                        end else if (|((r_board_a | r_board_b) & w_mask)) begin
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_OCCUPIED;
                        end else begin
                            if (r_turn) w_board_b_nxt = r_board_b | w_mask;
                            else        w_board_a_nxt = r_board_a | w_mask;
                            w_turn_nxt  = ~r_turn;
                            w_state_nxt = REQ;
                        end
                    end else if (w_byte == CH_R_LO || w_byte == CH_R_UP) begin
                        w_board_a_nxt = '0;
                        w_board_b_nxt = '0;
                        w_turn_nxt    = 1'b0;
                        w_state_nxt   = REQ;
                    end else if (w_byte != CH_CR && w_byte != CH_LF) begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_UNKNOWN;
                    end
                end
            end
            REQ: begin
                if (print_ready) begin
                    print_wr      = 1'b1;
                    w_ack_cnt_nxt = '0;
                    w_state_nxt   = ACK;
                end
            end
            ACK: begin
                if (!print_ready || r_ack_cnt == 2'd3) w_state_nxt = IDLE;
                else                                   w_ack_cnt_nxt = r_ack_cnt + 2'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign board_a  = r_board_a;
    assign board_b  = r_board_b;
    assign turn     = r_turn;
    assign winner   = w_winner;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign overflow = r_ovf;

endmodule

// File: doc/move_parser.md
Name: move_parser

Overview:
- Upstream stage of print_board.
- Consumes player keystrokes from uart_rx, for example '1'..'9' to place a mark and 'r' to restart.
- Maintains board_a and board_b, the alternating turn, and the winner/draw status.
- After every board change, issues a one-cycle wr request to print_board using the ready/wr handshake.

Parameters:
- ROWS, 3, board rows.
- COLS, 3, board columns. ROWS*COLS must be ≤ 9 so every cell has a single ASCII digit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- rx_rd  in  1  one-cycle strobe from uart_rx: rx_dout holds a valid byte.
- rx_dout  in  8  received byte.
- print_ready  in  1  print_board idle.
- print_wr  out  1  one-cycle print request.
- board_a  out  ROWS*COLS  player A marks; bit i = cell i+1.
- board_b  out  ROWS*COLS  player B marks.
- turn  out  1  0 = A to move, 1 = B to move.
- winner  out  2  00 none, 01 A, 10 B, 11 draw.
- err  out  1  one-cycle pulse when a byte is rejected.
- err_code  out  2  01 occupied cell, 10 unknown char, 11 game over. Held until the next err.
- overflow  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset values: boards 0, turn 0, winner 00, print_wr 0, err 0, err_code 00, overflow 0, pend_valid 0, state IDLE.
- Reset mid-print aborts the request. No wr is issued after reset deasserts.
- Byte intake:
  - There is a 1-entry pending register (pend_valid, pend_byte).
  - rx_rd in IDLE with pend_valid=0: the byte is decoded directly.
  - rx_rd in any other case: the byte is stored in pending if pend_valid=0. If pend_valid=1, the new byte is dropped and overflow pulses.
  - IDLE with pend_valid=1: the pending byte is decoded and pend_valid clears. A simultaneous rx_rd in that cycle is stored into pending, so no byte is lost.
- Decode (in IDLE, cycle t):
  - '1'..'N' (N = ROWS*COLS), winner=00, cell k free in both boards:
    - set bit k-1 in board_a (turn=0) or board_b (turn=1);
    - toggle turn;
    - state → REQ.
  - Digit, cell occupied: err, code 01. Boards and turn unchanged. Stay IDLE.
  - Valid digit while winner≠00: err, code 11.
  - 'r' or 'R': clear both boards, turn=0, state → REQ. Allowed in any game state.
  - '\r' or '\n': silently ignored, no err.
  - '0', digits > N, any other byte: err, code 10.
- Board registers update at t+1.
- winner is combinational from the board registers, so it is valid at t+1:
  - A (or B) completes any full row, any full column, or, when ROWS==COLS, either diagonal → 01 (or 10).
  - Otherwise, all cells filled → 11.
  - Otherwise 00.
  - A and B cannot both win, because moves are rejected once winner≠00.
- State machine IDLE → REQ → ACK → IDLE:
  - REQ: when print_ready=1, drive print_wr=1 for exactly one cycle and go to ACK. Earliest print_wr is t+1.
  - ACK: wait for print_ready=0, then go to IDLE. print_board drops ready within 1 cycle of wr.
  - ACK also returns to IDLE if ready stays high for 4 consecutive cycles. This guards against a print_board that completes instantly.
- print_wr never asserts in IDLE or ACK. Exactly one print is issued per accepted move or restart.
- Only one byte is decoded per IDLE cycle. Rejected bytes do not leave IDLE.

Decomposition:
- Package ttt_pkg holds:
  - ASCII constants (CH_0, CH_R_LO, CH_R_UP, CH_CR, CH_LF);
  - the winner codes;
  - the err codes;
  - the state enum (IDLE, REQ, ACK).
- One sub-module, win_detect (ROWS, COLS):
  - inputs board_a, board_b;
  - output winner[1:0];
  - purely combinational, built with generate loops over rows, columns and diagonals.

Test Plan:
- Bytes '1','5','2','6','3' (0x31,0x35,0x32,0x36,0x33), print_ready always 1:
  - board_a=9'b000000111, board_b=9'b000110000, winner=01;
  - exactly 5 print_wr pulses.
- '5' then '5': second byte gives err with code 01, board_a=9'b000010000, board_b=0, turn=1, one print_wr only.
- Bytes 'x', '0', 0x3A: three err pulses with code 10, boards unchanged, no print_wr. Then 0x0D gives no err.
- Fill for a draw with sequence 1,2,3,5,4,6,8,7,9:
  - winner=11;
  - a following '1' gives err code 11;
  - then 'r' clears both boards, turn=0, winner=00, one print_wr.
- Hold print_ready=0 and send '1','2','3' back-to-back:
  - '1' is applied;
  - '2' goes to pending;
  - '3' produces an overflow pulse.
  - After print_ready rises, ready falls and rises again, '2' is applied: board_b=9'b000000010.
- Assert reset low while in REQ:
  - all outputs return to their reset values immediately (asynchronously);
  - no print_wr after release;
  - pending byte discarded.
